// File: rtl/player_input_ctrl.sv
// Buzz-in capture for four players: sync, debounce, once-per-round recording, and a
// req/ack writer into the player slots at BASE_ADDR..BASE_ADDR+3.
// Optional build macro PLAYER_TIMESTAMP_EN: write reaction time instead of a buzz flag.
module player_input_ctrl #(
    parameter int WIDTH           = 16,
    parameter int RAM_ADDR_BITS   = 16,
    parameter logic [RAM_ADDR_BITS-1:0] BASE_ADDR = RAM_ADDR_BITS'(16'h0020),
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_BITS         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn,
    input  logic                     arm,
    output logic                     wr_req,
    input  logic                     wr_ack,
    output logic [RAM_ADDR_BITS-1:0] wr_adr,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     first_valid,
    output logic [1:0]               first_player,
    output logic [3:0]               pending,
    output logic                     state_dbg
);

    // Handshake: wr_req rises with wr_adr/wr_data valid and all three hold until the
    // cycle wr_ack is seen; the write completes on that edge and wr_req drops for at
    // least one cycle. wr_ack without wr_req has no effect.

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

    state_t               state, next_state;
    logic [3:0]           sync1, sync2;
    logic [3:0]           stable, stable_q;
    logic [DB_BITS-1:0]   db_cnt [4];
    logic [3:0]           press;
    logic                 armed;
    logic [3:0]           reported;
    logic [3:0]           accepted;
    logic [3:0]           pending_n;
    logic [3:0]           cur_mask;
    logic [1:0]           cur;
    logic [1:0]           sel;
    logic [WIDTH-1:0]     sel_data;
    logic                 start;
    logic                 done;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Two-flop synchroniser on the raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // A level change is accepted only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= '0;
            stable_q <= '0;
            press    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

    // arm in the same cycle as a press takes priority and the press is lost.
    assign accepted = press & ~reported & {4{armed & ~arm}};
    assign cur_mask = 4'b0001 << cur;
    assign sel      = lowest(pending);

    always_comb begin
        pending_n = pending;
        if (arm) begin
            pending_n = (state == REQ) ? (pending & cur_mask) : 4'b0000;
        end else begin
            pending_n = pending | accepted;
        end
        if (done) pending_n[cur] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if ((pending != 4'b0000) && !arm) begin
                    next_state = REQ;
                    start      = 1'b1;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign wr_req    = (state == REQ);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed        <= 1'b0;
            reported     <= '0;
            pending      <= '0;
            first_valid  <= 1'b0;
            first_player <= '0;
            cur          <= '0;
            wr_adr       <= '0;
            wr_data      <= '0;
        end else begin
            pending <= pending_n;
            if (arm) begin
                armed        <= 1'b1;
                reported     <= '0;
                first_valid  <= 1'b0;
                first_player <= '0;
            end else begin
                reported <= reported | accepted;
                if (!first_valid && (accepted != 4'b0000)) begin
                    first_valid  <= 1'b1;
                    first_player <= lowest(accepted);
                end
            end
            if (start) begin
                cur     <= sel;
                wr_adr  <= BASE_ADDR + RAM_ADDR_BITS'(sel);
                wr_data <= sel_data;
            end
        end
    end

`ifdef PLAYER_TIMESTAMP_EN
    logic [WIDTH-1:0] react_cnt;
    logic [WIDTH-1:0] ts_cap [4];

    // Reaction counter restarts on arm and sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            react_cnt <= '0;
            for (int i = 0; i < 4; i++) ts_cap[i] <= '0;
        end else begin
            if (arm) begin
                react_cnt <= '0;
            end else if (react_cnt != {WIDTH{1'b1}}) begin
                react_cnt <= react_cnt + 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (accepted[i]) ts_cap[i] <= react_cnt;
            end
        end
    end

    assign sel_data = ts_cap[sel];
`else
    assign sel_data = WIDTH'(1);
`endif

endmodule

// File: tb/tb_player_input_ctrl.sv
// Self-checking bench for player_input_ctrl with a short debounce window.
module tb_player_input_ctrl;

    localparam int W  = 16;
    localparam int AW = 16;
    localparam logic [AW-1:0] BASE = 16'h0020;
`ifdef PLAYER_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [3:0]    btn;
    logic          arm;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_adr;
    logic [W-1:0]  wr_data;
    logic          first_valid;
    logic [1:0]    first_player;
    logic [3:0]    pending;
    logic          state_dbg;

    int total;
    int bad;

    player_input_ctrl #(
        .WIDTH(W), .RAM_ADDR_BITS(AW), .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(4), .DB_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .arm(arm),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_adr(wr_adr), .wr_data(wr_data),
        .first_valid(first_valid), .first_player(first_player),
        .pending(pending), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn_mask;
        logic [3:0] glitch;
        int         ack_delay;
        logic       twice;
        logic [3:0] exp_writes;
        logic       exp_fv;
        logic [1:0] exp_fp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch_idle(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (wr_req !== 1'b0) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (wr_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, wr_req}, 1);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_ack();
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
    endtask

    // Expected writes: one per recorded player, lowest index first.
    task automatic serve(input logic [3:0] mask, input int ack_delay, input logic [W-1:0] exp_data);
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] exp_adr;
        logic [3:0]    remain;
        int            idx;
        int            hold_bad;
        remain = mask;
        for (int i = 0; i < 4; i++) if (mask[i]) exp_q.push_back(BASE + AW'(i));
        while (exp_q.size() > 0) begin
            exp_adr = exp_q.pop_front();
            idx = int'(exp_adr - BASE);
            wait_req();
            if (wr_req !== 1'b1) return;
            chk("adr", wr_adr, exp_adr);
            chk("data", wr_data, exp_data);
            chk("pend_before", pending, remain);
            hold_bad = 0;
            repeat (ack_delay) begin
                @(negedge clk);
                if (wr_req !== 1'b1 || wr_adr !== exp_adr || wr_data !== exp_data) hold_bad++;
            end
            chk("hold", hold_bad, 0);
            do_ack();
            remain[idx] = 1'b0;
            chk("req_drop", {31'd0, wr_req}, 0);
            chk("pend_after", pending, remain);
        end
    endtask

    task automatic run_ep(input vec_t v);
        pulse_arm();
        chk("arm_fv_clr", {31'd0, first_valid}, 0);
        chk("arm_pend_clr", pending, 0);
        btn = v.btn_mask | v.glitch;
        tick(2);
        btn = v.btn_mask;
        serve(v.exp_writes, v.ack_delay, TS ? W'(7) : W'(1));
        watch_idle("no_extra", 20);
        chk("first_valid", {31'd0, first_valid}, {31'd0, v.exp_fv});
        chk("first_player", first_player, v.exp_fp);
        if (v.twice) begin
            btn = 4'b0000;
            watch_idle("release", 12);
            btn = v.btn_mask;
            watch_idle("twice", 20);
        end
        btn = 4'b0000;
        tick(12);
    endtask

    initial begin
        vec_t rv;
        logic [3:0] m;
        total = 0;
        bad = 0;
        rst = 1'b1;
        btn = 4'b0000;
        arm = 1'b0;
        wr_ack = 1'b0;

        vecs[0] = '{4'b0100, 4'b0000, 3, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[1] = '{4'b0000, 4'b0010, 0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[2] = '{4'b1010, 4'b0000, 5, 1'b0, 4'b1010, 1'b1, 2'd1};
        vecs[3] = '{4'b0001, 4'b0000, 1, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[4] = '{4'b1111, 4'b0000, 0, 1'b0, 4'b1111, 1'b1, 2'd0};
        vecs[5] = '{4'b0110, 4'b1001, 2, 1'b0, 4'b0110, 1'b1, 2'd1};

        tick(3);
        rst = 1'b0;
        chk("rst_req", {31'd0, wr_req}, 0);
        chk("rst_adr", wr_adr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_fv", {31'd0, first_valid}, 0);
        chk("rst_fp", first_player, 0);
        chk("rst_pend", pending, 0);

        // Not yet armed: presses and stray acks are ignored.
        btn = 4'b1000;
        wr_ack = 1'b1;
        watch_idle("unarmed", 15);
        wr_ack = 1'b0;
        chk("unarmed_fv", {31'd0, first_valid}, 0);
        chk("unarmed_pend", pending, 0);
        btn = 4'b0000;
        tick(12);

        for (int i = 0; i < 6; i++) run_ep(vecs[i]);

        for (int i = 0; i < 10; i++) begin
            m = 4'($urandom_range(0, 15));
            rv.btn_mask   = m;
            rv.glitch     = 4'($urandom_range(0, 15)) & ~m;
            rv.ack_delay  = $urandom_range(0, 6);
            rv.twice      = 1'($urandom_range(0, 1));
            rv.exp_writes = m;
            rv.exp_fv     = (m != 4'b0000);
            rv.exp_fp     = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
            run_ep(rv);
        end

        // arm while a write is in flight: that write finishes, the rest are dropped.
        pulse_arm();
        btn = 4'b0011;
        wait_req();
        chk("inflight_adr", wr_adr, BASE);
        chk("inflight_pend", pending, 4'b0011);
        pulse_arm();
        chk("inflight_req", {31'd0, wr_req}, 1);
        chk("inflight_adr2", wr_adr, BASE);
        chk("inflight_pend2", pending, 4'b0001);
        chk("inflight_fv", {31'd0, first_valid}, 0);
        do_ack();
        chk("inflight_done", {31'd0, wr_req}, 0);
        chk("inflight_pend3", pending, 0);
        watch_idle("inflight_drop", 20);
        btn = 4'b0000;
        tick(12);

        // arm lands in the same cycle as the press pulse: press is lost.
        pulse_arm();
        btn = 4'b0001;
        tick(7);
        pulse_arm();
        watch_idle("arm_vs_press", 25);
        chk("arm_vs_press_fv", {31'd0, first_valid}, 0);
        chk("arm_vs_press_pend", pending, 0);
        btn = 4'b0000;
        tick(12);

        // Button rises 20 cycles after arm.
        pulse_arm();
        tick(20);
        btn = 4'b0001;
        wait_req();
        chk("ts_adr", wr_adr, BASE);
        chk("ts_data", wr_data, TS ? 32'd27 : 32'd1);
        do_ack();
        btn = 4'b0000;
        tick(12);

        // Reset while a request is outstanding.
        pulse_arm();
        btn = 4'b0001;
        wait_req();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'd0, wr_req}, 0);
        chk("midrst_pend", pending, 0);
        chk("midrst_fv", {31'd0, first_valid}, 0);
        chk("midrst_adr", wr_adr, 0);
        rst = 1'b0;
        watch_idle("midrst_unarmed", 20);
        btn = 4'b0000;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
